// File: rtl/board_scanner.sv
// Board scanner: snapshots the mine/flag/reveal maps on start, then streams
// the display code for all 64 tiles over a valid/ready handshake. While it
// streams, it accumulates win/loss/flag status. That status is published in
// the DONE cycle.
module board_scanner (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] mines,
  input  logic [63:0] flagged,
  input  logic [63:0] revealed,
  input  logic        tile_ready,
  output logic        tile_valid,
  output logic [5:0]  tile_index,
  output logic [3:0]  tile_code,
  output logic        busy,
  output logic        frame_done,
  output logic        game_won,
  output logic        game_lost,
  output logic [6:0]  flag_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [63:0] r_mines, r_flag, r_rev;
  logic [5:0]  r_idx;
  logic        r_acc_won, r_acc_lost;
  logic [6:0]  r_acc_flags;
  logic        r_won, r_lost;
  logic [6:0]  r_flag_count;

  logic [2:0]  w_row, w_col;
  logic        w_mine, w_flag, w_rev, w_xfer;
  logic [3:0]  w_nbr, w_code;
  int          w_nr, w_nc;

  assign w_row  = r_idx[5:3];
  assign w_col  = r_idx[2:0];
  assign w_mine = r_mines[r_idx];
  assign w_flag = r_flag[r_idx];
  assign w_rev  = r_rev[r_idx];
  assign w_xfer = (r_state == S_SCAN) && tile_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and handshake/status strobes
  always_comb begin
    w_next     = r_state;
    tile_valid = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_SCAN;
      S_SCAN: begin
        tile_valid = 1'b1;
        busy       = 1'b1;
        if (tile_ready && r_idx == 6'd63) w_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Count the mines among the in-board neighbours; rows and columns never wrap
  always_comb begin
    w_nbr = 4'd0;
    w_nr  = 0;
    w_nc  = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        w_nr = int'(w_row) + dr;
        w_nc = int'(w_col) + dc;
        if ((dr != 0 || dc != 0) && w_nr >= 0 && w_nr <= 7 && w_nc >= 0 && w_nc <= 7)
          w_nbr = w_nbr + {3'd0, r_mines[6'(w_nr * 8 + w_nc)]};
      end
    end
  end

  // Display code: revealed wins over flagged, and a revealed mine shows 11
  always_comb begin
    w_code = 4'd0;
    if (r_state == S_SCAN) begin
      if (w_rev)       w_code = w_mine ? 4'd11 : w_nbr;
      else if (w_flag) w_code = 4'd10;
      else             w_code = 4'd9;
    end
  end

  // Snapshot, index walk, accumulators and published status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mines      <= '0;
      r_flag       <= '0;
      r_rev        <= '0;
      r_idx        <= '0;
      r_acc_won    <= 1'b0;
      r_acc_lost   <= 1'b0;
      r_acc_flags  <= '0;
      r_won        <= 1'b0;
      r_lost       <= 1'b0;
      r_flag_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mines     <= mines;
          r_flag      <= flagged;
          r_rev       <= revealed;
          r_idx       <= '0;
          r_acc_won   <= 1'b1;
          r_acc_lost  <= 1'b0;
          r_acc_flags <= '0;
        end
        S_SCAN: if (w_xfer) begin
          if (w_rev && w_mine)   r_acc_lost <= 1'b1;
          if (!w_mine && !w_rev) r_acc_won  <= 1'b0;
          if (w_flag)            r_acc_flags <= r_acc_flags + 7'd1;
          if (r_idx != 6'd63)    r_idx <= r_idx + 6'd1;
        end
        S_DONE: begin
          r_won        <= r_acc_won;
          r_lost       <= r_acc_lost;
          r_flag_count <= r_acc_flags;
          r_idx        <= '0;
        end
        default: ;
      endcase
    end
  end

  assign tile_index = r_idx;
  assign tile_code  = w_code;
  assign game_won   = r_won;
  assign game_lost  = r_lost;
  assign flag_count = r_flag_count;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: hand-computed per-tile code tables,
// handshake stalls, mid-frame start and input changes, and reset mid-scan.
module tb_board_scanner;
  logic        clk, rst, start, tile_ready;
  logic [63:0] mines, flagged, revealed;
  logic        tile_valid, busy, frame_done, game_won, game_lost;
  logic [5:0]  tile_index;
  logic [3:0]  tile_code;
  logic [6:0]  flag_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_code [64];
  logic       prev_won, prev_lost;
  logic [6:0] prev_flags;

  board_scanner dut (
    .clk(clk), .rst(rst), .start(start), .mines(mines), .flagged(flagged),
    .revealed(revealed), .tile_ready(tile_ready), .tile_valid(tile_valid),
    .tile_index(tile_index), .tile_code(tile_code), .busy(busy),
    .frame_done(frame_done), .game_won(game_won), .game_lost(game_lost),
    .flag_count(flag_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 64; i++) exp_code[i] = v;
  endtask

  // One full frame. Inputs are scrambled as soon as start is taken, so the
  // codes can only come from the snapshot.
  task automatic run_frame(input logic [63:0] m, input logic [63:0] f, input logic [63:0] r,
                           input int stall_at, input int stall_n, input int restart_at,
                           input logic ew, input logic el, input logic [6:0] efc);
    mines = m; flagged = f; revealed = r; tile_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mines = ~m; flagged = ~f; revealed = ~r;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("valid[%0d]", i), tile_valid, 1'b1);
      chk($sformatf("index[%0d]", i), tile_index, i[5:0]);
      chk($sformatf("code[%0d]", i), tile_code, exp_code[i]);
      chk($sformatf("busy[%0d]", i), busy, 1'b1);
      chk($sformatf("done_lo[%0d]", i), frame_done, 1'b0);
      if (i == 0) begin
        chk("won_held", game_won, prev_won);
        chk("lost_held", game_lost, prev_lost);
        chk("flags_held", flag_count, prev_flags);
      end
      if (i == stall_at) begin
        tile_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk($sformatf("stall_index[%0d]", s), tile_index, i[5:0]);
          chk($sformatf("stall_code[%0d]", s), tile_code, exp_code[i]);
          chk($sformatf("stall_valid[%0d]", s), tile_valid, 1'b1);
        end
        tile_ready = 1'b1;
      end
      if (i == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("done_pulse", frame_done, 1'b1);
    chk("done_valid", tile_valid, 1'b0);
    chk("done_busy", busy, 1'b1);
    chk("done_won_old", game_won, prev_won);
    tick();
    chk("done_clear", frame_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("game_won", game_won, ew);
    chk("game_lost", game_lost, el);
    chk("flag_count", flag_count, efc);
    tick();
    chk("no_queued_busy", busy, 1'b0);
    chk("no_queued_done", frame_done, 1'b0);
    chk("status_hold", game_won, ew);
    prev_won = ew; prev_lost = el; prev_flags = efc;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tile_ready = 1'b1;
    mines = '0; flagged = '0; revealed = '0;
    prev_won = 1'b0; prev_lost = 1'b0; prev_flags = '0;
    #12;
    chk("rst_valid", tile_valid, 1'b0);
    chk("rst_index", tile_index, 6'd0);
    chk("rst_code", tile_code, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_won", game_won, 1'b0);
    chk("rst_lost", game_lost, 1'b0);
    chk("rst_flags", flag_count, 7'd0);
    rst = 1'b1;
    tick();

    // No mines, everything revealed: all codes 0
    fill(4'd0);
    run_frame(64'd0, 64'd0, ~64'd0, -1, 0, -1, 1'b1, 1'b0, 7'd0);

    // Corner mine at 0, rest revealed; stall 3 cycles on tile 5
    fill(4'd0);
    exp_code[0] = 4'd9; exp_code[1] = 4'd1; exp_code[8] = 4'd1; exp_code[9] = 4'd1;
    run_frame(64'd1, 64'd0, ~64'd1, 5, 3, -1, 1'b1, 1'b0, 7'd0);

    // Revealed mine at 27 gives a loss; 63 is revealed with no mines around it
    fill(4'd9);
    exp_code[27] = 4'd11; exp_code[63] = 4'd0;
    run_frame((64'd1 << 27) | 64'd1, 64'd0, (64'd1 << 27) | (64'd1 << 63),
              -1, 0, -1, 1'b0, 1'b1, 7'd0);

    // Flags on 0-9, nothing revealed, extra start mid-scan ignored
    fill(4'd9);
    for (int i = 0; i < 10; i++) exp_code[i] = 4'd10;
    run_frame(64'd0, 64'h3FF, 64'd0, -1, 0, 20, 1'b0, 1'b0, 7'd10);

    // Neighbour maxima: corner 0 -> 3, edge 4 -> 5, interior 36 -> 8
    fill(4'd9);
    exp_code[0] = 4'd3; exp_code[4] = 4'd5; exp_code[36] = 4'd8;
    run_frame(~(64'd1 | (64'd1 << 4) | (64'd1 << 36)), 64'd0,
              64'd1 | (64'd1 << 4) | (64'd1 << 36), -1, 0, -1, 1'b1, 1'b0, 7'd0);

    // Mine at 7 (row 0, col 7) must not reach 8 (row 1, col 0);
    // tile 8 is flagged and revealed, so its count shows and the flag still counts
    fill(4'd0);
    exp_code[6] = 4'd1; exp_code[14] = 4'd1; exp_code[15] = 4'd1; exp_code[7] = 4'd9;
    run_frame(64'd1 << 7, 64'd1 << 8, ~(64'd1 << 7), -1, 0, -1, 1'b1, 1'b0, 7'd1);

    // All mines, only tile 0 revealed: won and lost both set
    fill(4'd9);
    exp_code[0] = 4'd11;
    run_frame(~64'd0, 64'd0, 64'd1, -1, 0, -1, 1'b1, 1'b1, 7'd0);

    // Reset while tile 30 is presented
    mines = 64'd0; flagged = ~64'd0; revealed = ~64'd0; tile_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("pre_rst_index", tile_index, 6'd30);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", tile_valid, 1'b0);
    chk("mid_rst_index", tile_index, 6'd0);
    chk("mid_rst_code", tile_code, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", frame_done, 1'b0);
    chk("mid_rst_won", game_won, 1'b0);
    chk("mid_rst_lost", game_lost, 1'b0);
    chk("mid_rst_flags", flag_count, 7'd0);
    tick();
    chk("held_rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick();
    chk("post_rst_done", frame_done, 1'b0);
    prev_won = 1'b0; prev_lost = 1'b0; prev_flags = '0;
    fill(4'd0);
    run_frame(64'd0, 64'd0, ~64'd0, -1, 0, -1, 1'b1, 1'b0, 7'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
